// File: rtl/chiplet_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chiplet_types_pkg
// Description : Shared flit format used between chiplet switch blocks.
//               flit_t carries source/destination node IDs and a 32-bit
//               payload word.
// Revision    : 1.0 - initial release
// ============================================================================
package chiplet_types_pkg;

  typedef struct packed {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [31:0] payload;
  } flit_t;

endpackage
`default_nettype wire

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_pkg
// Description : Types and constants for the switch configuration bank:
//               config opcode enum, config header layout, route LUT entry
//               type, the dateline pseudo-address and the bank FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

  typedef enum logic [1:0] {
    CFG_OP_LUT_WR = 2'b00,
    CFG_OP_DL_WR  = 2'b01,
    CFG_OP_READ   = 2'b10,
    CFG_OP_RSVD   = 2'b11
  } cfg_op_t;

  // Header flit payload: [31:30] op, [29:22] addr, [21:0] ignored
  typedef struct packed {
    cfg_op_t     op;
    logic [7:0]  addr;
    logic [21:0] rsvd;
  } cfg_hdr_t;

  // One route table entry (output-port selection for a destination)
  typedef logic [7:0] route_lut_t;

  // Read-back address that selects the dateline register
  localparam logic [7:0] CFG_DATELINE_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_RESP      = 2'd2
  } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/switch_cfg_resp.sv
`default_nettype none
// ============================================================================
// Module      : switch_cfg_resp
// Description : Read-back response holder. Captures a formatted response
//               flit on load and presents it with out_valid until the
//               consumer accepts it with out_ready. The flit stays stable
//               while out_valid is high.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               load           - capture a new response this cycle
//               dst, payload   - response destination and data word
//               out_valid/out_flit/out_ready - response handshake
// Revision    : 1.0 - initial release
// ============================================================================
module switch_cfg_resp
  import chiplet_types_pkg::*;
#(
  parameter int NODE_ID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  dst,
  input  logic [31:0] payload,
  output logic        out_valid,
  output flit_t       out_flit,
  input  logic        out_ready
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else if (load) begin
      out_valid        <= 1'b1;
      out_flit.src     <= 8'(NODE_ID);
      out_flit.dst     <= dst;
      out_flit.payload <= payload;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module      : switch_cfg_bank
// Description : Configuration register bank for the chiplet switch. Consumes
//               two-flit (header, data) configuration transactions and
//               commits them to the route lookup table or the per-outport
//               dateline register. Claims the flit stream from route
//               compute while a transaction is open. Rejected transactions
//               pulse err for one cycle.
//               Optional read-back responses are enabled by defining the
//               macro SWITCH_CFG_READBACK_EN.
// Ports       : clk, rst              - clock, async active-high reset
//               in_valid, in_cfg      - head flit valid / targets config
//               in_flit, in_ready     - head flit and consume handshake
//               reg_bank_claim        - bank owns the flit stream
//               route_lut, dateline   - committed configuration state
//               err                   - one-cycle reject pulse
//               out_valid, out_flit,
//               out_ready             - response port (read-back builds only)
// Revision    : 1.0 - initial release
// ============================================================================
module switch_cfg_bank
  import chiplet_types_pkg::*;
  import switch_pkg::*;
#(
  parameter int NUM_OUTPORTS = 4,
  parameter int TABLE_SIZE   = 32,
  parameter int TOTAL_NODES  = 32,
  parameter int NODE_ID      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_cfg,
  input  flit_t                         in_flit,
  output logic                          in_ready,
  output logic                          reg_bank_claim,
  output route_lut_t [TABLE_SIZE-1:0]   route_lut,
  output logic [NUM_OUTPORTS-1:0]       dateline,
  output logic                          err
`ifdef SWITCH_CFG_READBACK_EN
  ,
  output logic                          out_valid,
  output flit_t                         out_flit,
  input  logic                          out_ready
`endif
);

  localparam int LUT_W = $bits(route_lut_t);

  cfg_state_t state;
  cfg_state_t next_state;
  cfg_hdr_t   hdr;
  cfg_op_t    cur_op;
  logic [7:0] cur_addr;

  logic hdr_take;   // write header accepted: latch op/addr
  logic commit;     // data flit accepted
  logic reject;     // transaction rejected this cycle (err next cycle)
  logic lut_addr_ok;
  logic lut_we;
  logic dl_we;

  assign hdr = cfg_hdr_t'(in_flit.payload);

  // Bound check on the latched write address
  assign lut_addr_ok = (32'(cur_addr) < 32'(TABLE_SIZE));
  assign lut_we      = commit && (cur_op == CFG_OP_LUT_WR) && lut_addr_ok;
  assign dl_we       = commit && (cur_op == CFG_OP_DL_WR);

  // Claim as soon as a config flit shows up so route compute never
  // forwards it, and keep claiming until the transaction closes.
  assign reg_bank_claim = (state != ST_IDLE) || (in_valid && in_cfg);

`ifdef SWITCH_CFG_READBACK_EN
  logic        rd_start;
  logic        rd_ok;
  logic [31:0] rd_data;

  // Read-back data is taken from the committed registers in the header
  // cycle; nothing can commit in the same cycle since the bank is idle.
  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b0;
    if (32'(hdr.addr) < 32'(TABLE_SIZE)) begin
      rd_ok = 1'b1;
      for (int i = 0; i < TABLE_SIZE; i++) begin
        if (hdr.addr == 8'(i)) begin
          rd_data = 32'(route_lut[i]);
        end
      end
    end else if (hdr.addr == CFG_DATELINE_ADDR) begin
      rd_ok   = 1'b1;
      rd_data = 32'(dateline);
    end
  end

  switch_cfg_resp #(
    .NODE_ID (NODE_ID)
  ) u_resp (
    .clk       (clk),
    .rst       (rst),
    .load      (rd_start),
    .dst       (in_flit.src),
    .payload   (rd_data),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .out_ready (out_ready)
  );
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    hdr_take   = 1'b0;
    commit     = 1'b0;
    reject     = 1'b0;
`ifdef SWITCH_CFG_READBACK_EN
    rd_start   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        // Non-config flits are left in the buffer for route compute
        in_ready = in_cfg;
        if (in_valid && in_cfg) begin
          case (hdr.op)
            CFG_OP_LUT_WR, CFG_OP_DL_WR: begin
              hdr_take   = 1'b1;
              next_state = ST_WAIT_DATA;
            end
            CFG_OP_READ: begin
`ifdef SWITCH_CFG_READBACK_EN
              rd_start   = 1'b1;
              reject     = !rd_ok;
              next_state = ST_RESP;
`else
              reject     = 1'b1;
`endif
            end
            default: begin
              reject = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT_DATA: begin
        // The data word is taken whatever its in_cfg marking
        in_ready = 1'b1;
        if (in_valid) begin
          commit     = 1'b1;
          reject     = (cur_op == CFG_OP_LUT_WR) && !lut_addr_ok;
          next_state = ST_IDLE;
        end
      end
      ST_RESP: begin
`ifdef SWITCH_CFG_READBACK_EN
        if (out_valid && out_ready) begin
          next_state = ST_IDLE;
        end
`else
        next_state = ST_IDLE;
`endif
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_op   <= CFG_OP_LUT_WR;
      cur_addr <= '0;
      dateline <= '0;
      err      <= 1'b0;
    end else begin
      err <= reject;
      if (hdr_take) begin
        cur_op   <= hdr.op;
        cur_addr <= hdr.addr;
      end
      if (dl_we) begin
        dateline <= in_flit.payload[NUM_OUTPORTS-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      route_lut <= '0;
    end else if (lut_we) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        if (cur_addr == 8'(i)) begin
          route_lut[i] <= in_flit.payload[LUT_W-1:0];
        end
      end
    end
  end

  // Header reserved bits, unused flit fields and sizing-only parameters
  logic unused_bits;
  assign unused_bits = ^{1'b0, in_flit, hdr.rsvd, 32'(TOTAL_NODES), 32'(NODE_ID)};

endmodule
`default_nettype wire

// File: tb/tb_switch_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_cfg_bank
// Description : Self-checking bench for switch_cfg_bank. A driver issues one
//               cycle of stimulus at a time and pushes the expected outputs
//               for that cycle, derived from a transaction-level model, into
//               a scoreboard queue; a monitor pops and compares on each
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_cfg_bank;
  import chiplet_types_pkg::*;
  import switch_pkg::*;

  localparam int NO  = 4;
  localparam int TS  = 32;
  localparam int NID = 1;
  localparam int LW  = $bits(route_lut_t);
  localparam int CW  = TS * LW;
`ifdef SWITCH_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_cfg = 1'b0;
  flit_t in_flit = '0;
  logic in_ready;
  logic reg_bank_claim;
  route_lut_t [TS-1:0] route_lut;
  logic [NO-1:0] dateline;
  logic err;
`ifdef SWITCH_CFG_READBACK_EN
  logic  out_valid;
  flit_t out_flit;
  logic  out_ready = 1'b0;
`endif

  switch_cfg_bank #(
    .NUM_OUTPORTS (NO),
    .TABLE_SIZE   (TS),
    .TOTAL_NODES  (32),
    .NODE_ID      (NID)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_cfg         (in_cfg),
    .in_flit        (in_flit),
    .in_ready       (in_ready),
    .reg_bank_claim (reg_bank_claim),
    .route_lut      (route_lut),
    .dateline       (dateline),
    .err            (err)
`ifdef SWITCH_CFG_READBACK_EN
    ,
    .out_valid      (out_valid),
    .out_flit       (out_flit),
    .out_ready      (out_ready)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rdy;
    logic          claim;
    logic          err;
    logic [NO-1:0] dl;
    logic [CW-1:0] lut;
    logic          ov;
    logic [31:0]   opl;
    logic [7:0]    odst;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int         m_lut[TS];
  int         m_dl;
  bit         m_err;
  bit         m_pend;      // write header seen, waiting for its data word
  int         m_pop;
  int         m_paddr;
  bit         m_busy;      // read response outstanding
  int         m_rpl;
  logic [7:0] m_rdst;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hdr(input int op, input int addr);
    logic [1:0] o;
    logic [7:0] a;
    o = 2'(op);
    a = 8'(addr);
    return {o, a, 22'h0};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < TS; i++) m_lut[i] = 0;
    m_dl = 0; m_err = 0; m_pend = 0; m_busy = 0; m_pop = 0; m_paddr = 0;
    m_rpl = 0; m_rdst = '0;
  endtask

  // One clock cycle of stimulus plus the expected outputs for that cycle
  task automatic step(input bit r, input bit v, input bit c, input logic [31:0] pl, input bit ordy);
    exp_t e;
    bit   nerr;
    int   op, addr;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_cfg = c;
    in_flit.payload = pl;
    in_flit.src = 8'($urandom);
    in_flit.dst = 8'($urandom);
`ifdef SWITCH_CFG_READBACK_EN
    out_ready = ordy;
`endif
    if (r) m_reset();
    e.rdy   = m_pend || (!m_busy && c);
    e.claim = m_pend || m_busy || (v && c);
    e.err   = m_err;
    e.dl    = NO'(m_dl);
    for (int i = 0; i < TS; i++) e.lut[i*LW +: LW] = LW'(m_lut[i]);
    e.ov    = m_busy;
    e.opl   = 32'(m_rpl);
    e.odst  = m_rdst;
    sb.push_back(e);
    if (!r) begin
      nerr = 0;
      op   = int'(pl[31:30]);
      addr = int'(pl[29:22]);
      if (m_busy) begin
        if (ordy) m_busy = 0;
      end else if (m_pend) begin
        if (v) begin
          m_pend = 0;
          if (m_pop == 0) begin
            if (m_paddr < TS) m_lut[m_paddr] = int'(pl) & ((1 << LW) - 1);
            else nerr = 1;
          end else begin
            m_dl = int'(pl) & ((1 << NO) - 1);
          end
        end
      end else if (v && c) begin
        if (op < 2) begin
          m_pend = 1; m_pop = op; m_paddr = addr;
        end else if (op == 2 && RB) begin
          m_busy = 1;
          m_rdst = in_flit.src;
          if (addr < TS) m_rpl = m_lut[addr];
          else if (addr == 255) m_rpl = m_dl;
          else begin m_rpl = 0; nerr = 1; end
        end else begin
          nerr = 1;
        end
      end
      m_err = nerr;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // Monitor: compares every cycle for which the driver queued an expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("in_ready", CW'(in_ready), CW'(e.rdy));
        chk("claim", CW'(reg_bank_claim), CW'(e.claim));
        chk("err", CW'(err), CW'(e.err));
        chk("dateline", CW'(dateline), CW'(e.dl));
        chk("route_lut", CW'(route_lut), e.lut);
`ifdef SWITCH_CFG_READBACK_EN
        chk("out_valid", CW'(out_valid), CW'(e.ov));
        if (e.ov) begin
          chk("out_payload", CW'(out_flit.payload), CW'(e.opl));
          chk("out_src", CW'(out_flit.src), CW'(NID));
          chk("out_dst", CW'(out_flit.dst), CW'(e.odst));
        end
`endif
      end
    end
  end

  initial begin
    logic [1:0]  rop;
    logic [7:0]  raddr;
    logic [31:0] rpl;
    int          sel;
    m_reset();
    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2);
    // LUT write addr 3 <= 0x5 (data flit not marked cfg)
    step(1'b0, 1'b1, 1'b1, hdr(0, 3), 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h5, 1'b1);
    idle(2);
    // Dateline write 0xA
    step(1'b0, 1'b1, 1'b1, hdr(1, 0), 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'hA, 1'b1);
    idle(2);
    // Out-of-range LUT write
    step(1'b0, 1'b1, 1'b1, hdr(0, 40), 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h99, 1'b1);
    idle(3);
    // Header, 5 idle cycles, then data 0x7 to addr 0
    step(1'b0, 1'b1, 1'b1, hdr(0, 0), 1'b1);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 32'h7, 1'b1);
    idle(2);
    // Read of addr 3 with out_ready low for 3 cycles (reserved when no read-back)
    step(1'b0, 1'b1, 1'b1, hdr(2, 3), 1'b0);
    step(1'b0, 1'b1, 1'b1, hdr(0, 1), 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(2);
    // Reserved op and dateline read
    step(1'b0, 1'b1, 1'b1, hdr(3, 3), 1'b1);
    step(1'b0, 1'b1, 1'b1, hdr(2, 255), 1'b1);
    idle(3);
    // Back-to-back header/data pairs
    step(1'b0, 1'b1, 1'b1, hdr(0, 31), 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h3C, 1'b1);
    step(1'b0, 1'b1, 1'b1, hdr(1, 7), 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h5, 1'b1);
    idle(2);
    // Reset during WAIT_DATA, then a non-cfg flit that must not be consumed
    step(1'b0, 1'b1, 1'b1, hdr(0, 3), 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h5, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h5, 1'b1);
    idle(2);
    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      rop = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 5) == 0)
        raddr = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(32, 254));
      else
        raddr = 8'($urandom_range(0, 31));
      rpl = {rop, raddr, 22'($urandom)};
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) < 7), rpl, ($urandom_range(0, 2) != 0));
    end
    idle(3);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/switch_cfg_bank.md
# switch_cfg_bank

Sequential configuration register bank for the chiplet switch. It consumes two-flit configuration transactions from the switch's input buffer and commits them to the route lookup table and the per-outport dateline register. While a transaction is in progress it asserts `reg_bank_claim` toward route compute, so route compute does not forward configuration flits. It replaces the static register-bank interface with a handshaked writer, bounds checking, and optional read-back responses.

## Interface
- `NUM_OUTPORTS`, default 4: number of switch output ports; width of `dateline`.
- `TABLE_SIZE`, default 32: number of `route_lut_t` entries.
- `TOTAL_NODES`, default 32: node count; carried for `route_lut_t` sizing.
- `NODE_ID`, default 1: this switch's node ID; used as the source of response flits.

Ports:
- `clk` input, 1: clock.
- `rst` input, 1: reset, asynchronous, active-high.
- `in_valid` input, 1: head flit of the configuration buffer is valid.
- `in_cfg` input, 1: head flit targets this switch's config space.
- `in_flit` input, `flit_t`: head flit; `payload` is 32 bits.
- `in_ready` output, 1: flit consumed when `in_valid & in_ready`.
- `reg_bank_claim` output, 1: bank owns the current flit stream.
- `route_lut` output, `route_lut_t [TABLE_SIZE-1:0]`: registered table.
- `dateline` output, `[NUM_OUTPORTS-1:0]`: registered dateline bits.
- `err` output, 1: one-cycle pulse on a rejected transaction.
- `out_valid`, `out_flit`, `out_ready`: response port. These exist only under the macro in Configuration.

## Operation
- Header flit payload layout:
  - [31:30] op: 00 = LUT write, 01 = dateline write, 10 = read, 11 = reserved.
  - [29:22] addr.
  - [21:0] ignored.
- The data flit payload is a 32-bit data word.
- States: IDLE, WAIT_DATA, RESP.
- IDLE:
  - Flit accepted with `in_cfg` = 1 and op 00 or 01: latch op and addr, go to WAIT_DATA.
  - Op 10: go to RESP when the macro is defined. Without the macro, pulse `err` and stay in IDLE.
  - Op 11: pulse `err`, stay in IDLE.
  - `in_valid` with `in_cfg` = 0: `in_ready` = 0, flit not consumed.
- WAIT_DATA: next accepted flit is the data word, regardless of `in_cfg`.
  - Op 00 with addr < TABLE_SIZE: `route_lut[addr] <= data[$bits(route_lut_t)-1:0]`.
  - Op 01: `dateline <= data[NUM_OUTPORTS-1:0]`; addr ignored.
  - Op 00 with addr >= TABLE_SIZE: no write, pulse `err`.
  - Return to IDLE in all cases.
- RESP: hold `out_valid` = 1 with a stable `out_flit` until `out_ready`, then go to IDLE.
- Output equations:
  - `in_ready` = (IDLE & `in_cfg`) | WAIT_DATA.
  - `reg_bank_claim` = (state != IDLE) | (`in_valid` & `in_cfg`).

## Timing
- Reset values:
  - `route_lut`: all entries zero.
  - `dateline`: zero.
  - `err`: 0.
  - `out_valid`: 0.
  - State: IDLE.
- Data flit accepted in cycle N: the new table or dateline value is visible at the cycle N+1 edge. `err` pulses in cycle N+1 for exactly one cycle.
- Back-to-back transactions: header, data, header, data are accepted in consecutive cycles with no bubble.
- `in_valid` low while in WAIT_DATA: wait indefinitely, holding claim.
- Reset asserted mid-transaction: go to IDLE immediately, clear all registers, drop `out_valid`. The partial transaction is discarded.
- `route_lut` and `dateline` change only on commit edges.

## Configuration
- Macro: `SWITCH_CFG_READBACK_EN`.
- Defined:
  - Response port present.
  - Read with addr < TABLE_SIZE returns a response with `payload` = zero-extended `route_lut[addr]`.
  - Read with addr = 8'hFF returns zero-extended `dateline`.
  - Any other out-of-range read returns payload 0 and pulses `err`.
  - Response header source is `NODE_ID`.
- Undefined: no response ports. Op 10 is treated as reserved (`err` pulse).

## Structure
- `switch_pkg` holds:
  - `cfg_op_t` enum.
  - `cfg_hdr_t` packed struct {op, addr, rsvd}.
  - `route_lut_t`.
  - Constant `CFG_DATELINE_ADDR` = 8'hFF.
- `chiplet_types_pkg` provides `flit_t`.
- Optional sub-module `switch_cfg_resp`: formats the response flit and holds it against `out_ready`.

## Test plan
- Reset, then LUT write of addr 3 with data 0x5: `route_lut[3]` = 0x5 one cycle after the data flit; all other entries 0; `err` = 0.
- Dateline write with data 0xA and NUM_OUTPORTS = 4: `dateline` = 4'b1010. `reg_bank_claim` is high from the header cycle through the data cycle.
- LUT write to addr 40 with TABLE_SIZE = 32: table unchanged, `err` high for exactly one cycle.
- Header accepted, `in_valid` low for 5 cycles, then data 0x7 to addr 0: state holds in WAIT_DATA, then `route_lut[0]` = 0x7.
- `rst` pulsed while in WAIT_DATA after a prior write of 0x5 to addr 3: `route_lut[3]` = 0, state IDLE. A following data-looking flit with `in_cfg` = 0 is not consumed.
- With the macro defined: read of addr 3 after writing 0x5, with `out_ready` held low for 3 cycles. `out_valid` and `out_flit` stay stable; `out_flit.payload` = 0x5; `in_ready` = 0 until `out_ready` is high.
